// File: rtl/line_beat_buffer.sv
// line_beat_buffer: converts between one cache line and a stream of AXI data beats.
//   FILL  : collects BEAT_COUNT inbound beats (beat 0 ends in the LSBs) into a line.
//   DRAIN : serialises a captured line into outbound beats, LSB beat first.
// Ports:
//   i_clk, i_arst_n                     clock, asynchronous active-low reset
//   i_fill_start, i_drain_start         start requests, honoured only in IDLE (drain wins)
//   i_abort                             return to IDLE from any state, no completion pulse
//   i_data_block                        line captured on an accepted drain start
//   i_beat_valid/i_beat_data/i_beat_last, o_beat_ready   inbound beat channel (FILL)
//   o_beat_valid/o_beat_data/o_beat_last, i_beat_ready   outbound beat channel (DRAIN)
//   o_data_block                        shift register contents
//   o_block_valid, o_drain_done         one-cycle completion pulses
//   o_busy                              not IDLE
//   o_last_err                          sticky inbound last-marker mismatch, cleared on start
module line_beat_buffer #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned BLOCK_WIDTH    = 512
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic                      i_fill_start,
  input  logic                      i_drain_start,
  input  logic                      i_abort,
  input  logic [BLOCK_WIDTH-1:0]    i_data_block,
  input  logic                      i_beat_valid,
  input  logic [AXI_DATA_WIDTH-1:0] i_beat_data,
  input  logic                      i_beat_last,
  output logic                      o_beat_ready,
  output logic                      o_beat_valid,
  output logic [AXI_DATA_WIDTH-1:0] o_beat_data,
  output logic                      o_beat_last,
  input  logic                      i_beat_ready,
  output logic [BLOCK_WIDTH-1:0]    o_data_block,
  output logic                      o_block_valid,
  output logic                      o_drain_done,
  output logic                      o_busy,
  output logic                      o_last_err
);

  localparam int unsigned BEAT_COUNT = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned CNT_W      = $clog2(BEAT_COUNT);

  if (BEAT_COUNT < 2 || (BLOCK_WIDTH % AXI_DATA_WIDTH) != 0) begin : g_bad_params
    $error("line_beat_buffer: BLOCK_WIDTH must be >= 2 whole beats of AXI_DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CNT_W-1:0]         r_count;
  logic [BLOCK_WIDTH-1:0]   r_shift;
  logic                     r_last_err;
  logic                     r_block_valid;
  logic                     r_drain_done;

  logic w_term;
  logic w_fill_acc;
  logic w_drain_acc;
  logic w_drain_go;
  logic w_fill_go;

  // Handshake qualifiers; abort suppresses every accept and start in its cycle
  assign w_term      = (r_count == CNT_W'(BEAT_COUNT - 1));
  assign w_fill_acc  = (r_state == S_FILL)  && i_beat_valid && !i_abort;
  assign w_drain_acc = (r_state == S_DRAIN) && i_beat_ready && !i_abort;
  assign w_drain_go  = (r_state == S_IDLE)  && i_drain_start && !i_abort;
  assign w_fill_go   = (r_state == S_IDLE)  && !i_drain_start && i_fill_start && !i_abort;

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (i_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_drain_start) begin
            w_next_state = S_DRAIN;
          end else if (i_fill_start) begin
            w_next_state = S_FILL;
          end
        end
        S_FILL: begin
          if (w_fill_acc && w_term) begin
            w_next_state = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_drain_acc && w_term) begin
            w_next_state = S_IDLE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state and datapath
  always_comb begin
    o_beat_ready  = 1'b0;
    o_beat_valid  = 1'b0;
    o_beat_last   = 1'b0;
    o_busy        = (r_state != S_IDLE);
    o_beat_data   = r_shift[AXI_DATA_WIDTH-1:0];
    o_data_block  = r_shift;
    o_block_valid = r_block_valid;
    o_drain_done  = r_drain_done;
    o_last_err    = r_last_err;
    case (r_state)
      S_FILL:  o_beat_ready = 1'b1;
      S_DRAIN: begin
        o_beat_valid = 1'b1;
        o_beat_last  = w_term;
      end
      default: ;
    endcase
  end

  // Datapath: beat counter, shift register, sticky error and completion pulses
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_count       <= '0;
      r_shift       <= '0;
      r_last_err    <= 1'b0;
      r_block_valid <= 1'b0;
      r_drain_done  <= 1'b0;
    end else begin
      r_block_valid <= w_fill_acc && w_term;
      r_drain_done  <= w_drain_acc && w_term;
      if (i_abort) begin
        r_count <= '0;
      end else if (w_drain_go) begin
        r_count    <= '0;
        r_shift    <= i_data_block;
        r_last_err <= 1'b0;
      end else if (w_fill_go) begin
        r_count    <= '0;
        r_last_err <= 1'b0;
      end else if (w_fill_acc) begin
        r_shift <= {i_beat_data, r_shift[BLOCK_WIDTH-1:AXI_DATA_WIDTH]};
        r_count <= w_term ? '0 : r_count + CNT_W'(1);
        if (i_beat_last != w_term) begin
          r_last_err <= 1'b1;
        end
      end else if (w_drain_acc) begin
        r_shift <= {AXI_DATA_WIDTH'(0), r_shift[BLOCK_WIDTH-1:AXI_DATA_WIDTH]};
        r_count <= w_term ? '0 : r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_beat_buffer.sv
// Scoreboard bench for line_beat_buffer (32-bit beats, 512-bit line).
module tb_line_beat_buffer;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 512;
  localparam int unsigned NB = BW / AW;

  typedef struct {
    logic [AW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_fill_start = 1'b0;
  logic          i_drain_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [BW-1:0] i_data_block = '0;
  logic          i_beat_valid = 1'b0;
  logic [AW-1:0] i_beat_data = '0;
  logic          i_beat_last = 1'b0;
  logic          o_beat_ready;
  logic          o_beat_valid;
  logic [AW-1:0] o_beat_data;
  logic          o_beat_last;
  logic          i_beat_ready = 1'b0;
  logic [BW-1:0] o_data_block;
  logic          o_block_valid;
  logic          o_drain_done;
  logic          o_busy;
  logic          o_last_err;

  int n_pass  = 0;
  int n_total = 0;

  beat_t         q_beat[$];
  logic [BW-1:0] q_block[$];
  int            q_done[$];

  line_beat_buffer #(.AXI_DATA_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .i_clk         (clk),
    .i_arst_n      (rst_n),
    .i_fill_start  (i_fill_start),
    .i_drain_start (i_drain_start),
    .i_abort       (i_abort),
    .i_data_block  (i_data_block),
    .i_beat_valid  (i_beat_valid),
    .i_beat_data   (i_beat_data),
    .i_beat_last   (i_beat_last),
    .o_beat_ready  (o_beat_ready),
    .o_beat_valid  (o_beat_valid),
    .o_beat_data   (o_beat_data),
    .o_beat_last   (o_beat_last),
    .i_beat_ready  (i_beat_ready),
    .o_data_block  (o_data_block),
    .o_block_valid (o_block_valid),
    .o_drain_done  (o_drain_done),
    .o_busy        (o_busy),
    .o_last_err    (o_last_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] pat(input logic [AW-1:0] seed, input int k);
    return seed ^ (AW'(k) * 32'h0101_0101);
  endfunction

  function automatic logic [BW-1:0] pat_block(input logic [AW-1:0] seed);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < int'(NB); k++) b[AW*k +: AW] = pat(seed, k);
    return b;
  endfunction

  task automatic push_beats(input logic [AW-1:0] seed, input int n, input bit with_done);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.d = pat(seed, k);
      e.l = (k == int'(NB) - 1);
      q_beat.push_back(e);
    end
    if (with_done) q_done.push_back(1);
  endtask

  // Bounded wait until every expected response has been observed
  task automatic wait_empty(input string name, input int bound);
    int n;
    n = 0;
    while ((q_beat.size() + q_block.size() + q_done.size()) != 0 && n < bound) begin
      tick();
      n++;
    end
    n_total++;
    if ((q_beat.size() + q_block.size() + q_done.size()) == 0) n_pass++;
    else $display("FAIL %s: %0d beats %0d blocks %0d done still expected", name,
                  q_beat.size(), q_block.size(), q_done.size());
  endtask

  // Monitor: pops and compares whenever the DUT presents a response
  logic          m_stall = 1'b0;
  logic [AW-1:0] m_data;
  logic          m_last;
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_stall && o_beat_valid) begin
        check("hold_data", BW'(o_beat_data), BW'(m_data));
        check("hold_last", BW'(o_beat_last), BW'(m_last));
      end
      if (o_beat_valid && i_beat_ready) begin
        if (q_beat.size() == 0) begin
          n_total++;
          $display("FAIL beat_unexpected: got data %0h with nothing expected", o_beat_data);
        end else begin
          beat_t e;
          e = q_beat.pop_front();
          check("beat_data", BW'(o_beat_data), BW'(e.d));
          check("beat_last", BW'(o_beat_last), BW'(e.l));
        end
      end
      if (o_block_valid) begin
        if (q_block.size() == 0) begin
          n_total++;
          $display("FAIL block_unexpected: got pulse 1 expected 0");
        end else begin
          check("block_data", o_data_block, q_block.pop_front());
        end
      end
      if (o_drain_done) begin
        n_total++;
        if (q_done.size() == 0) $display("FAIL done_unexpected: got pulse 1 expected 0");
        else begin
          void'(q_done.pop_front());
          n_pass++;
        end
      end
      m_stall = o_beat_valid && !i_beat_ready;
      m_data  = o_beat_data;
      m_last  = o_beat_last;
    end else begin
      m_stall = 1'b0;
    end
  end

  initial begin
    logic [BW-1:0] exp_blk;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", BW'(o_busy), BW'(0));
    check("rst_valid", BW'(o_beat_valid), BW'(0));
    check("rst_ready", BW'(o_beat_ready), BW'(0));
    check("rst_block", o_data_block, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Fill: beat i carries i, last on beat 15
    exp_blk = '0;
    for (int i = 0; i < int'(NB); i++) exp_blk[AW*i +: AW] = AW'(i);
    q_block.push_back(exp_blk);
    i_fill_start = 1'b1;
    tick();
    i_fill_start = 1'b0;
    check("fill_ready", BW'(o_beat_ready), BW'(1));
    for (int i = 0; i < int'(NB); i++) begin
      i_beat_valid = 1'b1;
      i_beat_data  = AW'(i);
      i_beat_last  = (i == int'(NB) - 1);
      tick();
    end
    i_beat_valid = 1'b0;
    i_beat_last  = 1'b0;
    check("fill_pulse_now", BW'(o_block_valid), BW'(1));
    wait_empty("fill_wait", 10);
    check("fill_last_err", BW'(o_last_err), BW'(0));
    check("fill_idle", BW'(o_busy), BW'(0));

    // Drain with toggling ready; both starts together must pick DRAIN
    i_data_block  = pat_block(32'hC0DE_0000);
    i_drain_start = 1'b1;
    i_fill_start  = 1'b1;
    tick();
    i_drain_start = 1'b0;
    i_fill_start  = 1'b0;
    check("prio_valid", BW'(o_beat_valid), BW'(1));
    check("prio_ready", BW'(o_beat_ready), BW'(0));
    push_beats(32'hC0DE_0000, int'(NB), 1'b1);
    for (int c = 0; c < 200 && (q_beat.size() + q_done.size()) != 0; c++) begin
      i_beat_ready = c[0];
      i_fill_start = (c == 4 || c == 5);
      tick();
    end
    i_beat_ready = 1'b0;
    i_fill_start = 1'b0;
    wait_empty("drain_wait", 5);
    check("drain_idle", BW'(o_busy), BW'(0));
    check("drain_no_fill", BW'(o_beat_ready), BW'(0));

    // Last marker on beat 7: error flagged, fill still takes 16 beats
    exp_blk = '0;
    for (int i = 0; i < int'(NB); i++) exp_blk[AW*i +: AW] = AW'(32'h1000 + i);
    q_block.push_back(exp_blk);
    i_fill_start = 1'b1;
    tick();
    i_fill_start = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      i_beat_valid = 1'b1;
      i_beat_data  = AW'(32'h1000 + i);
      i_beat_last  = (i == 7);
      tick();
      if (i == 6) check("lerr_before", BW'(o_last_err), BW'(0));
      if (i == 7) begin
        check("lerr_set", BW'(o_last_err), BW'(1));
        check("lerr_busy", BW'(o_busy), BW'(1));
      end
    end
    i_beat_valid = 1'b0;
    i_beat_last  = 1'b0;
    wait_empty("lerr_wait", 10);
    check("lerr_sticky", BW'(o_last_err), BW'(1));
    i_fill_start = 1'b1;
    tick();
    i_fill_start = 1'b0;
    check("lerr_clear", BW'(o_last_err), BW'(0));
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("fill_abort_idle", BW'(o_busy), BW'(0));

    // Abort after 5 drain beats, then a fresh full drain
    i_data_block  = pat_block(32'h5A5A_0F0F);
    i_drain_start = 1'b1;
    tick();
    i_drain_start = 1'b0;
    push_beats(32'h5A5A_0F0F, 5, 1'b0);
    i_beat_ready = 1'b1;
    repeat (5) tick();
    i_beat_ready = 1'b0;
    i_abort      = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_idle", BW'(o_busy), BW'(0));
    check("abort_valid", BW'(o_beat_valid), BW'(0));
    wait_empty("abort_wait", 3);
    repeat (3) tick();
    i_data_block  = pat_block(32'h1234_8765);
    i_drain_start = 1'b1;
    tick();
    i_drain_start = 1'b0;
    push_beats(32'h1234_8765, int'(NB), 1'b1);
    i_beat_ready = 1'b1;
    wait_empty("redrain_wait", 40);
    i_beat_ready = 1'b0;

    // Asynchronous reset in the middle of a drain
    i_data_block  = pat_block(32'hC0DE_0000);
    i_drain_start = 1'b1;
    tick();
    i_drain_start = 1'b0;
    push_beats(32'hC0DE_0000, 3, 1'b0);
    i_beat_ready = 1'b1;
    repeat (3) tick();
    i_beat_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", BW'(o_beat_valid), BW'(0));
    check("arst_busy", BW'(o_busy), BW'(0));
    check("arst_block", o_data_block, '0);
    tick();
    rst_n = 1'b1;
    wait_empty("final_wait", 3);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
